// File: rtl/op_decoder_seq.sv
// Sequenced opcode decoder: one-hot select for single-cycle codes, held select for multi-cycle codes.
// Define OP_DECODER_ILLEGAL_CNT_EN to add the saturating reserved-code counter port illegal_count_o.
module op_decoder_seq #(
  parameter int                    SEL_W         = 3,
  parameter logic [(2**SEL_W)-1:0] MULTI_MASK    = 8'h30,
  parameter int                    MULTI_CYCLES  = 4,
  parameter int                    RESERVED_CODE = (2**SEL_W) - 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic [SEL_W-1:0]        operation_i,
  output logic [(2**SEL_W)-1:0]   select_o,
  output logic                    sel_valid_o,
  output logic                    busy_o,
  output logic                    illegal_o
`ifdef OP_DECODER_ILLEGAL_CNT_EN
  ,
  output logic [7:0]              illegal_count_o
`endif
);

  localparam int N_OUT = 2**SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [SEL_W-1:0] RES_CODE  = SEL_W'(RESERVED_CODE);
  localparam logic [3:0]       HOLD_LOAD = 4'(MULTI_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [N_OUT-1:0] select_q, select_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             handshake;
  logic             is_reserved;

  // Ready is withheld during reset and in HOLD until the last held cycle.
  assign op_ready_o  = ~reset_i & ((state_q != ST_HOLD) | (cnt_q == 4'd0));
  assign handshake   = op_valid_i & op_ready_o;
  assign is_reserved = (operation_i == RES_CODE);

  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    if (handshake) begin
      if (is_reserved) begin
        state_d   = ST_IDLE;
        select_d  = '0;
        cnt_d     = 4'd0;
        illegal_d = 1'b1;
      end else if (MULTI_MASK[operation_i]) begin
        state_d  = ST_HOLD;
        select_d = N_OUT'(1) << operation_i;
        cnt_d    = HOLD_LOAD;
      end else begin
        state_d  = ST_SINGLE;
        select_d = N_OUT'(1) << operation_i;
        cnt_d    = 4'd0;
      end
    end else if ((state_q == ST_HOLD) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d  = ST_IDLE;
      select_d = '0;
      cnt_d    = 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      select_q  <= '0;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign select_o    = select_q;
  assign sel_valid_o = |select_q;
  assign busy_o      = (state_q == ST_HOLD);
  assign illegal_o   = illegal_q;

`ifdef OP_DECODER_ILLEGAL_CNT_EN
  logic [7:0] illcnt_q;

  // Counts on the same edge that raises illegal_o and sticks at 255.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      illcnt_q <= 8'd0;
    end else if (handshake && is_reserved && (illcnt_q != 8'hFF)) begin
      illcnt_q <= illcnt_q + 8'd1;
    end
  end

  assign illegal_count_o = illcnt_q;
`endif

endmodule

// File: tb/tb_op_decoder_seq.sv
// Self-checking bench for op_decoder_seq: directed scenarios plus random traffic against a cycle model.
// Build with OP_DECODER_ILLEGAL_CNT_EN defined to also exercise illegal_count_o.
module tb_op_decoder_seq;

  logic       clk;
  logic       rst;
  logic       opValid;
  logic       opReady;
  logic [2:0] operation;
  logic [7:0] select;
  logic       selValid;
  logic       busy;
  logic       illegal;
`ifdef OP_DECODER_ILLEGAL_CNT_EN
  logic [7:0] illegalCount;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: how many more cycles the current code stays visible.
  int remaining  = 0;
  int curCode    = 0;
  bit illegalNow = 1'b0;
  int illegalCnt = 0;
  bit inReset    = 1'b1;

  op_decoder_seq dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .op_valid_i     (opValid),
    .op_ready_o     (opReady),
    .operation_i    (operation),
    .select_o       (select),
    .sel_valid_o    (selValid),
    .busy_o         (busy),
    .illegal_o      (illegal)
`ifdef OP_DECODER_ILLEGAL_CNT_EN
    ,
    .illegal_count_o(illegalCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isMulti(input int c);
    return (c == 4) || (c == 5);
  endfunction

  function automatic bit modelReady();
    return !inReset && (remaining <= 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic checkAll();
    logic [7:0] expSel;
    expSel = (remaining > 0) ? (8'd1 << curCode) : 8'd0;
    checkOutput("select",    32'(select),   32'(expSel));
    checkOutput("sel_valid", 32'(selValid), 32'(remaining > 0));
    checkOutput("busy",      32'(busy),     32'((remaining > 0) && isMulti(curCode)));
    checkOutput("illegal",   32'(illegal),  32'(illegalNow));
    checkOutput("op_ready",  32'(opReady),  32'(modelReady()));
`ifdef OP_DECODER_ILLEGAL_CNT_EN
    checkOutput("illegal_count", 32'(illegalCount), 32'(illegalCnt));
`endif
  endtask

  function automatic void modelReset();
    remaining  = 0;
    curCode    = 0;
    illegalNow = 1'b0;
    illegalCnt = 0;
  endfunction

  // One clock cycle: drive, check the current cycle, then advance the model across the edge.
  task automatic applyStimulus(input bit v, input int op);
    bit hs;
    @(negedge clk);
    opValid   = v;
    operation = 3'(op);
    #1;
    checkAll();
    hs = v && modelReady();
    @(posedge clk);
    if (hs) begin
      illegalNow = (op == 7);
      if (op == 7) begin
        remaining  = 0;
        illegalCnt = (illegalCnt < 255) ? illegalCnt + 1 : 255;
      end else begin
        curCode   = op;
        remaining = isMulti(op) ? 4 : 1;
      end
    end else begin
      illegalNow = 1'b0;
      if (remaining > 0) remaining--;
    end
  endtask

  initial begin
    rst       = 1'b1;
    opValid   = 1'b0;
    operation = 3'd0;
    modelReset();
    inReset = 1'b1;

    // Reset state, with a handshake attempt that must be ignored.
    @(negedge clk);
    opValid   = 1'b1;
    operation = 3'd1;
    #1;
    checkAll();
    @(negedge clk);
    rst     = 1'b0;
    opValid = 1'b0;
    inReset = 1'b0;
    #1;
    checkAll();

    // Single codes back-to-back with valid held.
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    applyStimulus(1, 2);
    applyStimulus(1, 3);
    applyStimulus(1, 6);
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    // Multi code 4 followed immediately by code 1.
    applyStimulus(1, 4);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    // Reserved code pulse.
    applyStimulus(1, 7);
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    // Code 2 offered during HOLD while not ready must be ignored.
    applyStimulus(1, 5);
    applyStimulus(1, 2);
    applyStimulus(1, 2);
    applyStimulus(0, 2);
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    // Asynchronous reset in the second HOLD cycle of code 5.
    applyStimulus(1, 5);
    applyStimulus(0, 0);
    #2;
    rst = 1'b1;
    #1;
    inReset = 1'b1;
    modelReset();
    checkAll();
    @(negedge clk);
    opValid   = 1'b1;
    operation = 3'd1;
    @(negedge clk);
    rst     = 1'b0;
    opValid = 1'b0;
    inReset = 1'b0;
    #1;
    checkAll();
    applyStimulus(0, 0);

`ifdef OP_DECODER_ILLEGAL_CNT_EN
    // Counter saturation after 300 reserved codes.
    for (int i = 0; i < 300; i++) applyStimulus(1, 7);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)));
    end
    applyStimulus(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
